uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with idle-timeout end-of-transfer detection.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       valid_out,
    output logic       data_end,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                rx_meta_r;
    logic                rx_sync_r;
    logic                rx_prev_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          shift_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic                armed_r;
    logic                baud_clr_s;
    logic                shift_en_s;
    logic                stop_en_s;
    logic                good_s;
`ifdef UART_RX_PARITY_EN
    logic                par_en_s;
    logic                parity_bad_r;
    logic                parity_err_r;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle sampling strobes.
    always_comb begin
        state_next_s = state_r;
        baud_clr_s   = 1'b0;
        shift_en_s   = 1'b0;
        stop_en_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                baud_clr_s = 1'b1;
                if (rx_prev_r && !rx_sync_r) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (baud_cnt_r == HALF_LAST) begin
                    baud_clr_s   = 1'b1;
                    state_next_s = rx_sync_r ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (baud_cnt_r == BIT_LAST) begin
                    baud_clr_s = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_r == BIT_LAST) begin
                    baud_clr_s   = 1'b1;
                    par_en_s     = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is caught.
                if (baud_cnt_r == BIT_LAST) begin
                    baud_clr_s   = 1'b1;
                    stop_en_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                baud_clr_s   = 1'b1;
                state_next_s = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign good_s     = stop_en_s && rx_sync_r && !parity_bad_r;
    assign parity_err = parity_err_r;
`else
    assign good_s     = stop_en_s && rx_sync_r;
    assign parity_err = 1'b0;
`endif

    // Synchronizer, bit timing, shift register and frame result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            byte_out   <= 8'h00;
            valid_out  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            baud_cnt_r <= baud_clr_s ? '0 : baud_cnt_r + BAUD_W'(1);
            if (state_r == IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {rx_sync_r, shift_r[7:1]};
            end
            valid_out <= good_s;
            frame_err <= stop_en_s && !rx_sync_r;
            if (good_s) begin
                byte_out <= shift_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity check; a bad stop bit overrides the parity error.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bad_r <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (par_en_s) begin
                parity_bad_r <= rx_sync_r ^ (^shift_r);
            end else if (state_r == IDLE) begin
                parity_bad_r <= 1'b0;
            end
            parity_err_r <= stop_en_s && rx_sync_r && parity_bad_r;
        end
    end
`endif

    // Idle timeout: armed by a good byte, fires data_end once after a quiet line.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= '0;
            armed_r    <= 1'b0;
            data_end   <= 1'b0;
        end else begin
            data_end <= 1'b0;
            if (good_s) begin
                armed_r    <= 1'b1;
                idle_cnt_r <= '0;
            end else if (!rx_sync_r) begin
                idle_cnt_r <= '0;
            end else if (armed_r && (state_r == IDLE)) begin
                if (idle_cnt_r == IDLE_LAST) begin
                    data_end   <= 1'b1;
                    armed_r    <= 1'b0;
                    idle_cnt_r <= '0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit and a 4-bit idle timeout.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int IDLB = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] byte_out;
    logic       valid_out;
    logic       data_end;
    logic       frame_err;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    int cycle       = 0;
    int valid_cnt   = 0;
    int end_cnt     = 0;
    int ferr_cnt    = 0;
    int perr_cnt    = 0;
    int overlap_cnt = 0;
    int last_valid_cyc = 0;
    int last_end_cyc   = 0;
    logic [7:0] byte_log [0:255];

    uart_rx #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_out   (byte_out),
        .valid_out  (valid_out),
        .data_end   (data_end),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: counts pulses and logs received bytes.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (valid_out) begin
            byte_log[valid_cnt[7:0]] <= byte_out;
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cycle;
        end
        if (data_end) begin
            end_cnt      <= end_cnt + 1;
            last_end_cyc <= cycle;
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if ((32'(valid_out) + 32'(data_end) + 32'(frame_err) + 32'(parity_err)) > 1)
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== par) send_bit(1'b1);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_raw(d, ^d, stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(2);
        n_checks++;
        if (byte_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_byte: got %h expected 00", byte_out);
        end
        n_checks++;
        if ({valid_out, data_end, frame_err, parity_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0000",
                               {valid_out, data_end, frame_err, parity_err});
        end
    endtask

    task automatic test_single;
        int v0 = valid_cnt;
        int e0 = end_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        wait_cycles(40);
        n_checks++;
        if (end_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL single_early_end: got %0d data_end expected 0", end_cnt - e0);
        end
        wait_cycles(60);
        n_checks++;
        if (valid_cnt - v0 !== 1) begin
            n_fail++; $display("FAIL single_valid: got %0d pulses expected 1", valid_cnt - v0);
        end
        n_checks++;
        if (byte_log[v0[7:0]] !== 8'hA5) begin
            n_fail++; $display("FAIL single_byte: got %h expected a5", byte_log[v0[7:0]]);
        end
        n_checks++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0);
        end
        n_checks++;
        if (end_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL single_end: got %0d data_end expected 1", end_cnt - e0);
        end
        n_checks++;
        if (last_end_cyc - last_valid_cyc !== IDLB * CPB) begin
            n_fail++; $display("FAIL single_end_delay: got %0d cycles expected %0d",
                               last_end_cyc - last_valid_cyc, IDLB * CPB);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int v0 = valid_cnt;
        int e0 = end_cnt;
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
        n_checks++;
        if (end_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL b2b_mid_end: got %0d data_end expected 0", end_cnt - e0);
        end
        wait_cycles(100);
        n_checks++;
        if (valid_cnt - v0 !== 4) begin
            n_fail++; $display("FAIL b2b_valid: got %0d pulses expected 4", valid_cnt - v0);
        end
        for (int i = 0; i < 4; i++) begin
            int idx = v0 + i;
            n_checks++;
            if (byte_log[idx[7:0]] !== exp_b[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, byte_log[idx[7:0]], exp_b[i]);
            end
        end
        n_checks++;
        if (end_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL b2b_end: got %0d data_end expected 1", end_cnt - e0);
        end
        n_checks++;
        if (last_end_cyc - last_valid_cyc !== IDLB * CPB) begin
            n_fail++; $display("FAIL b2b_end_delay: got %0d cycles expected %0d",
                               last_end_cyc - last_valid_cyc, IDLB * CPB);
        end
    endtask

    task automatic test_frame_err;
        int v0 = valid_cnt;
        int e0 = end_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        wait_cycles(100);
        n_checks++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0);
        end
        n_checks++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL ferr_valid: got %0d pulses expected 0", valid_cnt - v0);
        end
        n_checks++;
        if (byte_out !== 8'h12) begin
            n_fail++; $display("FAIL ferr_byte_hold: got %h expected 12", byte_out);
        end
        n_checks++;
        if (end_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL ferr_end: got %0d data_end expected 0", end_cnt - e0);
        end
    endtask

    task automatic test_false_start;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        int p0 = perr_cnt;
        int e0 = end_cnt;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(60);
        n_checks++;
        if ((valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0) + (end_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL false_start_pulses: got %0d expected 0",
                               (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0) + (end_cnt - e0));
        end
        send_frame(8'h5A, 1'b1);
        wait_cycles(100);
        n_checks++;
        if (valid_cnt - v0 !== 1 || byte_log[v0[7:0]] !== 8'h5A) begin
            n_fail++; $display("FAIL false_start_recover: got %0d pulses byte %h expected 1 pulse byte 5a",
                               valid_cnt - v0, byte_log[v0[7:0]]);
        end
    endtask

    task automatic test_reset_mid;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        int e0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_cycles(8);
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        n_checks++;
        if (byte_out !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_byte: got %h expected 00", byte_out);
        end
        e0 = end_cnt;
        wait_cycles(110);
        n_checks++;
        if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
            n_fail++; $display("FAIL rst_mid_discard: got %0d valid %0d ferr expected 0 0",
                               valid_cnt - v0, ferr_cnt - f0);
        end
        n_checks++;
        if (end_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL rst_idle_end: got %0d data_end expected 0", end_cnt - e0);
        end
        send_frame(8'h0F, 1'b1);
        wait_cycles(100);
        n_checks++;
        if (valid_cnt - v0 !== 1 || byte_log[v0[7:0]] !== 8'h0F) begin
            n_fail++; $display("FAIL rst_mid_next: got %0d pulses byte %h expected 1 pulse byte 0f",
                               valid_cnt - v0, byte_log[v0[7:0]]);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0 = valid_cnt;
        int p0 = perr_cnt;
        send_raw(8'h01, 1'b0, 1'b1);
        wait_cycles(30);
        n_checks++;
        if (perr_cnt - p0 !== 1 || valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL parity_bad: got %0d perr %0d valid expected 1 0",
                               perr_cnt - p0, valid_cnt - v0);
        end
        n_checks++;
        if (byte_out !== 8'h0F) begin
            n_fail++; $display("FAIL parity_bad_hold: got %h expected 0f", byte_out);
        end
        send_raw(8'h01, 1'b1, 1'b1);
        wait_cycles(100);
        n_checks++;
        if (perr_cnt - p0 !== 1 || valid_cnt - v0 !== 1 || byte_out !== 8'h01) begin
            n_fail++; $display("FAIL parity_good: got %0d perr %0d valid byte %h expected 1 1 01",
                               perr_cnt - p0, valid_cnt - v0, byte_out);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_false_start();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_checks++;
        if (overlap_cnt !== 0) begin
            n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", overlap_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
